// File: rtl/cache_mem_arbiter.sv
// Purpose: grants the shared memory port to the I-cache or D-cache, one transaction at a time.
// Latency: req sampled in IDLE -> m_req next cycle; dok is combinational with m_data_ok (min 2 cycles).
// Backpressure: the non-granted req is simply left pending; X_ADDR/X_DATA wait indefinitely on memory.
module cache_mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_dok,
    input  logic              d_req,
    input  logic              d_wr,
    input  logic [3:0]        d_wstrb,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_dok,
    output logic              m_req,
    output logic              m_wr,
    output logic [3:0]        m_wstrb,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic              m_addr_ok,
    input  logic              m_data_ok,
    input  logic [DATA_W-1:0] m_rdata
);

    typedef enum logic [2:0] {IDLE, I_ADDR, I_DATA, D_ADDR, D_DATA} state_t;

    localparam logic LG_I = 1'b0;
    localparam logic LG_D = 1'b1;

    state_t state, state_nxt;
    logic   last_grant, last_grant_nxt;
    logic   grant_i, grant_d;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state      <= IDLE;
            last_grant <= LG_I;
        end else begin
            state      <= state_nxt;
            last_grant <= last_grant_nxt;
        end
    end

    // last_grant only moves on a genuine conflict; lone requests are granted without touching it.
    always_comb begin
        state_nxt      = state;
        last_grant_nxt = last_grant;
        grant_i        = 1'b0;
        grant_d        = 1'b0;
        case (state)
            IDLE: begin
                if (i_req && d_req) begin
                    if (last_grant == LG_I) grant_d = 1'b1;
                    else                    grant_i = 1'b1;
                    last_grant_nxt = ~last_grant;
                end else if (d_req) begin
                    grant_d = 1'b1;
                end else if (i_req) begin
                    grant_i = 1'b1;
                end
                if (grant_d)      state_nxt = D_ADDR;
                else if (grant_i) state_nxt = I_ADDR;
            end
            I_ADDR: if (m_addr_ok) state_nxt = I_DATA;
            I_DATA: if (m_data_ok) state_nxt = IDLE;
            D_ADDR: if (m_addr_ok) state_nxt = D_DATA;
            D_DATA: if (m_data_ok) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Request fields are latched only at grant so the memory side sees them stable until IDLE.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            m_wr    <= 1'b0;
            m_wstrb <= 4'b0000;
            m_addr  <= '0;
            m_wdata <= '0;
        end else if (grant_d) begin
            m_wr    <= d_wr;
            m_wstrb <= d_wr ? d_wstrb : 4'b0000;
            m_addr  <= d_addr;
            m_wdata <= d_wdata;
        end else if (grant_i) begin
            m_wr    <= 1'b0;
            m_wstrb <= 4'b0000;
            m_addr  <= i_addr;
        end
    end

    assign m_req   = (state == I_ADDR) || (state == D_ADDR);
    assign i_dok   = m_data_ok && (state == I_DATA);
    assign d_dok   = m_data_ok && (state == D_DATA);
    assign i_rdata = m_rdata;
    assign d_rdata = m_rdata;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed scenarios plus a randomized run scored against a transaction-level arbiter model.
module tb_cache_mem_arbiter;

    logic        clk = 1'b0;
    logic        resetn;
    logic        i_req, d_req, d_wr;
    logic [31:0] i_addr, d_addr, d_wdata;
    logic [3:0]  d_wstrb;
    logic [31:0] i_rdata, d_rdata;
    logic        i_dok, d_dok;
    logic        m_req, m_wr;
    logic [3:0]  m_wstrb;
    logic [31:0] m_addr, m_wdata, m_rdata;
    logic        m_addr_ok, m_data_ok;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    cache_mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .resetn(resetn),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_dok(i_dok),
        .d_req(d_req), .d_wr(d_wr), .d_wstrb(d_wstrb), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_rdata(d_rdata), .d_dok(d_dok),
        .m_req(m_req), .m_wr(m_wr), .m_wstrb(m_wstrb), .m_addr(m_addr),
        .m_wdata(m_wdata), .m_addr_ok(m_addr_ok), .m_data_ok(m_data_ok),
        .m_rdata(m_rdata)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        i_req = 0; i_addr = 0; d_req = 0; d_wr = 0; d_wstrb = 0; d_addr = 0; d_wdata = 0;
        m_addr_ok = 0; m_data_ok = 0; m_rdata = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        resetn = 0;
        cyc();
        cyc();
        resetn = 1;
    endtask

    task automatic test_reset();
        clear_inputs();
        i_req = 1; d_req = 1;
        resetn = 0;
        cyc();
        cyc();
        smp();
        checks++; if (m_req !== 1'b0) begin errors++; $display("FAIL rst_m_req: got %b want 0", m_req); end
        checks++; if (m_wr !== 1'b0) begin errors++; $display("FAIL rst_m_wr: got %b want 0", m_wr); end
        checks++; if (m_wstrb !== 4'b0) begin errors++; $display("FAIL rst_m_wstrb: got %b want 0000", m_wstrb); end
        checks++; if (m_addr !== 32'h0) begin errors++; $display("FAIL rst_m_addr: got %h want 0", m_addr); end
        checks++; if (m_wdata !== 32'h0) begin errors++; $display("FAIL rst_m_wdata: got %h want 0", m_wdata); end
        checks++; if ({i_dok, d_dok} !== 2'b00) begin errors++; $display("FAIL rst_dok: got %b want 00", {i_dok, d_dok}); end
        cyc();
        do_reset();
    endtask

    task automatic test_d_read();
        do_reset();
        d_req = 1; d_wr = 0; d_wstrb = 4'hF; d_addr = 32'h1FAF_F000;
        smp();
        checks++; if (m_req !== 1'b0) begin errors++; $display("FAIL rd_c0_m_req: got %b want 0", m_req); end
        cyc();
        m_addr_ok = 1;
        smp();
        checks++; if (m_req !== 1'b1) begin errors++; $display("FAIL rd_c1_m_req: got %b want 1", m_req); end
        checks++; if (m_addr !== 32'h1FAF_F000) begin errors++; $display("FAIL rd_c1_m_addr: got %h want 1faff000", m_addr); end
        checks++; if (m_wstrb !== 4'b0000) begin errors++; $display("FAIL rd_c1_m_wstrb: got %b want 0000", m_wstrb); end
        checks++; if (m_wr !== 1'b0) begin errors++; $display("FAIL rd_c1_m_wr: got %b want 0", m_wr); end
        cyc();
        m_addr_ok = 0;
        smp();
        checks++; if ({m_req, d_dok, i_dok} !== 3'b000) begin errors++; $display("FAIL rd_c2_idle: got %b want 000", {m_req, d_dok, i_dok}); end
        cyc();
        m_data_ok = 1; m_rdata = 32'hDEADBEEF;
        smp();
        checks++; if (d_dok !== 1'b1) begin errors++; $display("FAIL rd_c3_d_dok: got %b want 1", d_dok); end
        checks++; if (d_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_c3_d_rdata: got %h want deadbeef", d_rdata); end
        checks++; if (i_dok !== 1'b0) begin errors++; $display("FAIL rd_c3_i_dok: got %b want 0", i_dok); end
        cyc();
        d_req = 0; m_data_ok = 0;
        smp();
        checks++; if ({m_req, d_dok} !== 2'b00) begin errors++; $display("FAIL rd_c4_done: got %b want 00", {m_req, d_dok}); end
    endtask

    task automatic test_d_write();
        do_reset();
        d_req = 1; d_wr = 1; d_wstrb = 4'b0011; d_wdata = 32'h1234_5678; d_addr = 32'h0000_0040;
        cyc();
        m_addr_ok = 1;
        smp();
        checks++; if (m_wr !== 1'b1) begin errors++; $display("FAIL wr_m_wr: got %b want 1", m_wr); end
        checks++; if (m_wstrb !== 4'b0011) begin errors++; $display("FAIL wr_m_wstrb: got %b want 0011", m_wstrb); end
        checks++; if (m_wdata !== 32'h1234_5678) begin errors++; $display("FAIL wr_m_wdata: got %h want 12345678", m_wdata); end
        checks++; if (m_addr !== 32'h0000_0040) begin errors++; $display("FAIL wr_m_addr: got %h want 00000040", m_addr); end
        cyc();
        m_addr_ok = 0; m_data_ok = 1;
        smp();
        checks++; if ({d_dok, i_dok} !== 2'b10) begin errors++; $display("FAIL wr_dok: got %b want 10", {d_dok, i_dok}); end
        cyc();
        d_req = 0; m_data_ok = 0;
        cyc();
    endtask

    task automatic test_conflict();
        do_reset();
        i_req = 1; i_addr = 32'h0000_0100;
        d_req = 1; d_addr = 32'h0000_0200; d_wr = 0;
        smp();
        checks++; if (m_req !== 1'b0) begin errors++; $display("FAIL cf_c0_m_req: got %b want 0", m_req); end
        cyc();
        for (int t = 0; t < 4; t++) begin
            automatic bit          exp_d = (t % 2 == 0);
            automatic logic [31:0] ea    = exp_d ? 32'h0000_0200 : 32'h0000_0100;
            m_addr_ok = 1;
            smp();
            checks++; if (m_req !== 1'b1) begin errors++; $display("FAIL cf_t%0d_m_req: got %b want 1", t, m_req); end
            checks++; if (m_addr !== ea) begin errors++; $display("FAIL cf_t%0d_grant_addr: got %h want %h", t, m_addr, ea); end
            cyc();
            m_addr_ok = 0; m_data_ok = 1; m_rdata = 32'hA000_0000 + t;
            smp();
            checks++; if ({d_dok, i_dok} !== {exp_d, !exp_d}) begin errors++; $display("FAIL cf_t%0d_dok: got %b want %b", t, {d_dok, i_dok}, {exp_d, !exp_d}); end
            cyc();
            m_data_ok = 0;
            smp();
            checks++; if (m_req !== 1'b0) begin errors++; $display("FAIL cf_t%0d_k1_m_req: got %b want 0", t, m_req); end
            cyc();
        end
        clear_inputs();
        cyc();
    endtask

    task automatic test_addr_stability();
        do_reset();
        d_req = 1; d_wr = 1; d_wstrb = 4'b1010; d_addr = 32'h0000_1234; d_wdata = 32'hCAFE_F00D;
        cyc();
        for (int t = 0; t < 5; t++) begin
            d_addr = ~d_addr; d_wdata = d_wdata + 1; d_wstrb = ~d_wstrb; d_wr = ~d_wr;
            smp();
            checks++; if (m_req !== 1'b1) begin errors++; $display("FAIL st_t%0d_m_req: got %b want 1", t, m_req); end
            checks++; if (m_addr !== 32'h0000_1234) begin errors++; $display("FAIL st_t%0d_m_addr: got %h want 00001234", t, m_addr); end
            checks++; if ({m_wr, m_wstrb} !== 5'b1_1010) begin errors++; $display("FAIL st_t%0d_wr_strb: got %b want 11010", t, {m_wr, m_wstrb}); end
            checks++; if (m_wdata !== 32'hCAFE_F00D) begin errors++; $display("FAIL st_t%0d_m_wdata: got %h want cafef00d", t, m_wdata); end
            cyc();
        end
        m_addr_ok = 1; m_data_ok = 1; m_rdata = 32'h5555_AAAA;
        smp();
        checks++; if (d_dok !== 1'b0) begin errors++; $display("FAIL st_both_ok_d_dok: got %b want 0", d_dok); end
        cyc();
        m_addr_ok = 0; m_data_ok = 0; d_addr = 32'hFFFF_0000;
        smp();
        checks++; if ({m_req, d_dok} !== 2'b00) begin errors++; $display("FAIL st_ddata_wait: got %b want 00", {m_req, d_dok}); end
        checks++; if (m_addr !== 32'h0000_1234) begin errors++; $display("FAIL st_ddata_m_addr: got %h want 00001234", m_addr); end
        cyc();
        m_data_ok = 1;
        smp();
        checks++; if (d_dok !== 1'b1) begin errors++; $display("FAIL st_ddata_d_dok: got %b want 1", d_dok); end
        cyc();
        clear_inputs();
        cyc();
    endtask

    task automatic test_reset_mid_op();
        do_reset();
        i_req = 1; i_addr = 32'h0000_0080;
        cyc();
        m_addr_ok = 1;
        cyc();
        m_addr_ok = 0;
        resetn = 0;
        cyc();
        i_req = 0;
        smp();
        checks++; if ({m_req, m_wr, m_wstrb} !== 6'b0) begin errors++; $display("FAIL rm_ctrl: got %b want 000000", {m_req, m_wr, m_wstrb}); end
        checks++; if (m_addr !== 32'h0) begin errors++; $display("FAIL rm_m_addr: got %h want 0", m_addr); end
        checks++; if (m_wdata !== 32'h0) begin errors++; $display("FAIL rm_m_wdata: got %h want 0", m_wdata); end
        cyc();
        resetn = 1;
        m_data_ok = 1;
        smp();
        checks++; if ({i_dok, d_dok} !== 2'b00) begin errors++; $display("FAIL rm_stray_dok: got %b want 00", {i_dok, d_dok}); end
        cyc();
        smp();
        checks++; if ({i_dok, d_dok, m_req} !== 3'b000) begin errors++; $display("FAIL rm_stray_dok2: got %b want 000", {i_dok, d_dok, m_req}); end
        cyc();
        m_data_ok = 0;
    endtask

    // Model: at most one transaction in flight; its owner and request fields are frozen at grant.
    task automatic test_random();
        bit          busy, aphase, owner_d, lg_d, i_drop, d_drop, ei, ed;
        logic [31:0] e_addr, e_wdata;
        logic        e_wr;
        logic [3:0]  e_wstrb;
        do_reset();
        busy = 0; aphase = 0; owner_d = 0; lg_d = 0; i_drop = 0; d_drop = 0;
        e_addr = 0; e_wdata = 0; e_wr = 0; e_wstrb = 0;
        for (int c = 0; c < 800; c++) begin
            if (i_drop) begin i_req = 0; i_drop = 0; end
            else if (!i_req && $urandom_range(2) == 0) i_req = 1;
            if (d_drop) begin d_req = 0; d_drop = 0; end
            else if (!d_req && $urandom_range(2) == 0) d_req = 1;
            i_addr = $urandom; d_addr = $urandom; d_wdata = $urandom;
            d_wr = 1'($urandom_range(1)); d_wstrb = 4'($urandom);
            m_addr_ok = ($urandom_range(2) == 0);
            m_data_ok = ($urandom_range(2) == 0);
            m_rdata = $urandom;
            smp();
            ei = busy && !aphase && !owner_d && m_data_ok;
            ed = busy && !aphase && owner_d && m_data_ok;
            checks++; if (m_req !== (busy && aphase)) begin errors++; $display("FAIL rnd%0d_m_req: got %b want %b", c, m_req, busy && aphase); end
            checks++; if (m_addr !== e_addr) begin errors++; $display("FAIL rnd%0d_m_addr: got %h want %h", c, m_addr, e_addr); end
            checks++; if ({m_wr, m_wstrb} !== {e_wr, e_wstrb}) begin errors++; $display("FAIL rnd%0d_wr_strb: got %b want %b", c, {m_wr, m_wstrb}, {e_wr, e_wstrb}); end
            checks++; if (m_wdata !== e_wdata) begin errors++; $display("FAIL rnd%0d_m_wdata: got %h want %h", c, m_wdata, e_wdata); end
            checks++; if ({i_dok, d_dok} !== {ei, ed}) begin errors++; $display("FAIL rnd%0d_dok: got %b want %b", c, {i_dok, d_dok}, {ei, ed}); end
            checks++; if ({i_rdata, d_rdata} !== {m_rdata, m_rdata}) begin errors++; $display("FAIL rnd%0d_rdata: got %h/%h want %h", c, i_rdata, d_rdata, m_rdata); end
            if (ei) i_drop = 1;
            if (ed) d_drop = 1;
            if (!busy) begin
                if (i_req || d_req) begin
                    if (i_req && d_req) begin
                        owner_d = !lg_d;
                        lg_d    = owner_d;
                    end else begin
                        owner_d = d_req;
                    end
                    busy = 1; aphase = 1;
                    if (owner_d) begin
                        e_addr = d_addr; e_wr = d_wr; e_wstrb = d_wr ? d_wstrb : 4'b0000; e_wdata = d_wdata;
                    end else begin
                        e_addr = i_addr; e_wr = 0; e_wstrb = 4'b0000;
                    end
                end
            end else if (aphase) begin
                if (m_addr_ok) aphase = 0;
            end else if (m_data_ok) begin
                busy = 0;
            end
            cyc();
        end
        clear_inputs();
        cyc();
    endtask

    initial begin
        clear_inputs();
        resetn = 0;
        test_reset();
        test_d_read();
        test_d_write();
        test_conflict();
        test_addr_stability();
        test_reset_mid_op();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cache_mem_arbiter.md
# cache_mem_arbiter

Two-master arbiter sharing the single word-wide memory port between the instruction cache and the data cache. Each cache raises a level `req` and holds it until a one-cycle `dok` pulse returns. The arbiter grants one cache at a time, drives a registered address/data phase toward memory, and routes the response back to the granted cache. It sits between the two cache controllers and the AXI bridge, and it is the only path from either cache to memory.

## Interface
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width (fixed at 32; `wstrb` is 4 bits)
- `clk`  in  1  clock
- `resetn`  in  1  reset, synchronous, active-low
- `i_req`  in  1  instruction cache request, held until `i_dok`
- `i_addr`  in  32  instruction fetch address (read only)
- `i_rdata`  out  32  read data, valid when `i_dok`=1
- `i_dok`  out  1  one-cycle completion pulse
- `d_req`  in  1  data cache request, held until `d_dok`
- `d_wr`  in  1  1 = write-back or uncached store, 0 = line/word load
- `d_wstrb`  in  4  byte enables for a write; ignored when `d_wr`=0
- `d_addr`  in  32  data address
- `d_wdata`  in  32  write data
- `d_rdata`  out  32  read data, valid when `d_dok`=1
- `d_dok`  out  1  one-cycle completion pulse
- `m_req`  out  1  memory address-phase request
- `m_wr`  out  1  memory write
- `m_wstrb`  out  4  memory byte enables, 4'b0000 on reads
- `m_addr`  out  32  memory address
- `m_wdata`  out  32  memory write data
- `m_addr_ok`  in  1  address phase accepted
- `m_data_ok`  in  1  data phase complete; `m_rdata` valid
- `m_rdata`  in  32  memory read data

## Operation
- FSM states: `IDLE`, `I_ADDR`, `I_DATA`, `D_ADDR`, `D_DATA`.
- `IDLE`:
  - Only `d_req`: go to `D_ADDR`.
  - Only `i_req`: go to `I_ADDR`.
  - Both: grant the master opposite to `last_grant`, then update `last_grant`.
  - Neither: stay in `IDLE`.
  - Grant decisions use only `req` values sampled in `IDLE`.
- Capture at grant (same edge as leaving `IDLE`), into the registered outputs:
  - D grant: `m_addr`←`d_addr`, `m_wr`←`d_wr`, `m_wstrb`←`d_wr`?`d_wstrb`:0, `m_wdata`←`d_wdata`.
  - I grant: `m_addr`←`i_addr`, `m_wr`←0, `m_wstrb`←0, `m_wdata` unchanged.
- `X_ADDR` (X = I or D):
  - `m_req`=1.
  - On `m_addr_ok`: go to `X_DATA`. `m_req` is low from the next cycle.
- `X_DATA`:
  - `m_req`=0.
  - On `m_data_ok`: `X_dok`=1 that same cycle, combinational. Next state is `IDLE`.
  - `m_data_ok` outside `X_DATA` is ignored, with no `dok`.
- Response routing:
  - `i_rdata` = `d_rdata` = `m_rdata` (broadcast).
  - `i_dok` = `m_data_ok` & (state==`I_DATA`).
  - `d_dok` = `m_data_ok` & (state==`D_DATA`).
- Requester contract: drop `req` in the cycle after `dok`. A `req` still high in that `IDLE` cycle is a new request.
- `last_grant` resets to I, so the first conflict goes to D. Under continuous dual requests, grants alternate D,I,D,I.
- The non-granted master's `req` is held and never dropped by the arbiter. Its `dok` stays 0.
- Exactly one transaction is outstanding at a time. No pipelining of address phases.

## Timing
- Reset values: state `IDLE`, `last_grant`=I, `m_req`=0, `m_wr`=0, `m_wstrb`=0, `m_addr`=0, `m_wdata`=0, `i_dok`=0, `d_dok`=0.
- Latency:
  - `req` sampled in `IDLE` at cycle 0.
  - `m_req` high in cycle 1.
  - With `m_addr_ok` in cycle 1 and `m_data_ok` in cycle 2, `dok` comes in cycle 2: minimum 2 cycles.
- Back-to-back: `dok` in cycle k, `IDLE` in k+1, next `m_req` in k+2.
- `m_addr_ok` and `m_data_ok` together in an `X_ADDR` cycle: accept the address only. Data completion is taken in `X_DATA`.
- `m_addr`, `m_wr`, `m_wstrb`, `m_wdata` are stable from grant until `IDLE`, even if the requester changes its inputs.
- Reset mid-transaction: next edge returns to `IDLE` with all reset values and no `dok`. Memory shares `resetn` and discards the transaction.
- Waiting is unbounded in `X_ADDR` and `X_DATA`. There is no timeout.

## Test plan
- Single D read: `d_req`=1, `d_wr`=0, `d_addr`=0x1FAF_F000.
  - `m_req`=1 in cycle 1 with `m_addr`=0x1FAF_F000 and `m_wstrb`=0.
  - `m_addr_ok` in cycle 1, `m_data_ok` with `m_rdata`=0xDEADBEEF in cycle 3.
  - Expect `d_dok`=1 with `d_rdata`=0xDEADBEEF in cycle 3, and `i_dok`=0 throughout.
- D write: `d_wr`=1, `d_wstrb`=4'b0011, `d_wdata`=0x1234_5678, `d_addr`=0x0000_0040.
  - Expect `m_wr`=1, `m_wstrb`=0011, `m_wdata`=0x12345678.
  - `d_dok` on `m_data_ok`.
- Conflict after reset: `i_req` and `d_req` both rise in cycle 0.
  - D is served first.
  - Expect `m_req` for `i_addr` in cycle k+2 after `d_dok` in cycle k.
  - With both held continuously for 4 transactions, grant order is D,I,D,I.
- Address stability: `m_addr_ok` delayed 5 cycles while `d_addr` toggles.
  - `m_addr` holds the captured value.
  - A same-cycle `m_addr_ok`+`m_data_ok` in `D_ADDR` gives no `d_dok` until `m_data_ok` is seen in `D_DATA`.
- Reset mid-op: assert `resetn`=0 in `I_DATA`.
  - Next cycle all outputs are at reset values.
  - A stray `m_data_ok` after reset produces no `dok`.
